// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: address-width limits, pointer typedefs, Gray conversions.
// Pure declarations; no latency or flow control of its own.
package fifo_pkg;

    localparam int MIN_ADDRWIDTH = 2;
    localparam int MAX_ADDRWIDTH = 12;

    // Widest pointer/level any legal instance needs (one extra bit for wrap).
    typedef logic [MAX_ADDRWIDTH:0] ptr_max_t;
    typedef logic [MAX_ADDRWIDTH:0] level_max_t;

    function automatic int ptr_width(input int addrwidth);
        return addrwidth + 1;
    endfunction

    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        logic     acc;
        b   = '0;
        acc = 1'b0;
        for (int i = MAX_ADDRWIDTH; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Gray-to-binary converter (prefix XOR from the MSB down), shared by read and write sides.
// Purely combinational, zero latency; no flow control.
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    logic acc;

    always_comb begin
        bin = '0;
        acc = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
    end

endmodule

// File: rtl/rptr_level.sv
// Async-FIFO read pointer with empty/almost-empty/level flags and sticky underflow.
// Flags register one edge after the read or wptr change; reads while empty are dropped and flagged.
module rptr_level
    import fifo_pkg::*;
#(
    parameter int ADDRWIDTH = 4,
    parameter int AEMPTY_W  = ADDRWIDTH + 1
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 rinc,
    input  logic [ADDRWIDTH:0]   rq2_wptr,
    input  logic [AEMPTY_W-1:0]  aempty_thresh,
    input  logic                 uf_clr,
    output logic                 rempty,
    output logic                 raempty,
    output logic [ADDRWIDTH-1:0] raddr,
    output logic [ADDRWIDTH:0]   rptr,
    output logic [ADDRWIDTH:0]   rlevel,
    output logic                 runderflow
);

    localparam int PW = ADDRWIDTH + 1;
    localparam int CW = (AEMPTY_W > PW) ? AEMPTY_W : PW;

    generate
        if (ADDRWIDTH < MIN_ADDRWIDTH || ADDRWIDTH > MAX_ADDRWIDTH) begin : g_bad_addrwidth
            $error("rptr_level: ADDRWIDTH %0d outside legal range %0d..%0d",
                   ADDRWIDTH, MIN_ADDRWIDTH, MAX_ADDRWIDTH);
        end
    endgenerate

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbinnext;
    logic [PW-1:0] rgraynext;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;
    logic [CW-1:0] level_ext;
    logic [CW-1:0] thresh_ext;
    logic          rd_en;
    logic          uf_evt;

    gray2bin #(
        .WIDTH (PW)
    ) u_wptr_g2b (
        .gray (rq2_wptr),
        .bin  (wbin)
    );

    // A read only advances when the FIFO is known non-empty.
    assign rd_en      = rinc & ~rempty;
    assign uf_evt     = rinc & rempty;
    assign rbinnext   = rbin + {{ADDRWIDTH{1'b0}}, rd_en};
    assign rgraynext  = (rbinnext >> 1) ^ rbinnext;
    assign level_next = wbin - rbinnext;
    assign level_ext  = CW'(level_next);
    assign thresh_ext = CW'(aempty_thresh);
    assign raddr      = rbin[ADDRWIDTH-1:0];

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin       <= '0;
            rptr       <= '0;
            rempty     <= 1'b1;
            raempty    <= 1'b1;
            rlevel     <= '0;
            runderflow <= 1'b0;
        end else begin
            rbin    <= rbinnext;
            rptr    <= rgraynext;
            rempty  <= (rgraynext == rq2_wptr);
            raempty <= (level_ext <= thresh_ext);
            rlevel  <= level_next;
            // A fresh underflow on the same edge beats a clear request.
            if (uf_evt) begin
                runderflow <= 1'b1;
            end else if (uf_clr) begin
                runderflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rptr_level.sv
module tb_rptr_level;

    localparam int AW = 4;
    localparam int PW = AW + 1;

    logic          rclk;
    logic          rrst_n;
    logic          rinc;
    logic [PW-1:0] rq2_wptr;
    logic [PW-1:0] aempty_thresh;
    logic          uf_clr;
    logic          rempty;
    logic          raempty;
    logic [AW-1:0] raddr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] rlevel;
    logic          runderflow;

    int n_checks = 0;
    int n_fail   = 0;

    rptr_level #(
        .ADDRWIDTH (AW),
        .AEMPTY_W  (PW)
    ) dut (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .rinc          (rinc),
        .rq2_wptr      (rq2_wptr),
        .aempty_thresh (aempty_thresh),
        .uf_clr        (uf_clr),
        .rempty        (rempty),
        .raempty       (raempty),
        .raddr         (raddr),
        .rptr          (rptr),
        .rlevel        (rlevel),
        .runderflow    (runderflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [PW-1:0] gray_of(input int b);
        logic [PW-1:0] v;
        v = PW'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic test_reset();
        rrst_n = 1'b0; rinc = 1'b1; rq2_wptr = 5'b00011; uf_clr = 1'b0; aempty_thresh = 5'd2;
        step();
        step();
        n_checks++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL reset_rempty got %b want 1", rempty); end
        n_checks++; if (raempty !== 1'b1) begin n_fail++; $display("FAIL reset_raempty got %b want 1", raempty); end
        n_checks++; if (rptr !== 5'd0) begin n_fail++; $display("FAIL reset_rptr got %b want 00000", rptr); end
        n_checks++; if (raddr !== 4'd0) begin n_fail++; $display("FAIL reset_raddr got %0d want 0", raddr); end
        n_checks++; if (rlevel !== 5'd0) begin n_fail++; $display("FAIL reset_rlevel got %0d want 0", rlevel); end
        n_checks++; if (runderflow !== 1'b0) begin n_fail++; $display("FAIL reset_runderflow got %b want 0", runderflow); end
    endtask

    task automatic test_fill();
        rrst_n = 1'b1; rinc = 1'b0; rq2_wptr = 5'b00010;
        step();
        n_checks++; if (rempty !== 1'b0) begin n_fail++; $display("FAIL fill_rempty got %b want 0", rempty); end
        n_checks++; if (rlevel !== 5'd3) begin n_fail++; $display("FAIL fill_rlevel got %0d want 3", rlevel); end
        n_checks++; if (raempty !== 1'b0) begin n_fail++; $display("FAIL fill_raempty got %b want 0", raempty); end
    endtask

    task automatic test_drain();
        logic [PW-1:0] exp_ptr [3];
        int            exp_lvl [3];
        exp_ptr = '{5'b00001, 5'b00011, 5'b00010};
        exp_lvl = '{2, 1, 0};
        rinc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (rptr !== exp_ptr[i]) begin n_fail++; $display("FAIL drain_rptr[%0d] got %b want %b", i, rptr, exp_ptr[i]); end
            n_checks++; if (rlevel !== PW'(exp_lvl[i])) begin n_fail++; $display("FAIL drain_rlevel[%0d] got %0d want %0d", i, rlevel, exp_lvl[i]); end
            n_checks++; if (raempty !== 1'b1) begin n_fail++; $display("FAIL drain_raempty[%0d] got %b want 1", i, raempty); end
            n_checks++; if (rempty !== (i == 2)) begin n_fail++; $display("FAIL drain_rempty[%0d] got %b want %b", i, rempty, i == 2); end
        end
        rinc = 1'b0;
    endtask

    task automatic test_underflow();
        rinc = 1'b1;
        step();
        rinc = 1'b0;
        n_checks++; if (rptr !== 5'b00010) begin n_fail++; $display("FAIL uf_rptr_hold got %b want 00010", rptr); end
        n_checks++; if (runderflow !== 1'b1) begin n_fail++; $display("FAIL uf_set got %b want 1", runderflow); end
        step();
        n_checks++; if (runderflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky got %b want 1", runderflow); end
        uf_clr = 1'b1;
        step();
        uf_clr = 1'b0;
        n_checks++; if (runderflow !== 1'b0) begin n_fail++; $display("FAIL uf_clear got %b want 0", runderflow); end
        uf_clr = 1'b1; rinc = 1'b1;
        step();
        uf_clr = 1'b0; rinc = 1'b0;
        n_checks++; if (runderflow !== 1'b1) begin n_fail++; $display("FAIL uf_set_wins got %b want 1", runderflow); end
        uf_clr = 1'b1;
        step();
        uf_clr = 1'b0;
    endtask

    task automatic test_wrap();
        // rbin is 3 here: advance to 19, then to 31, in legal bursts of at most 16.
        rq2_wptr = gray_of(19); rinc = 1'b0;
        step();
        rinc = 1'b1;
        repeat (16) step();
        rinc = 1'b0; rq2_wptr = gray_of(31);
        step();
        rinc = 1'b1;
        repeat (12) step();
        rinc = 1'b0;
        n_checks++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL wrap_preload_empty got %b want 1", rempty); end
        rq2_wptr = 5'b00001;
        step();
        n_checks++; if (rlevel !== 5'd2) begin n_fail++; $display("FAIL wrap_rlevel got %0d want 2", rlevel); end
        n_checks++; if (raddr !== 4'd15) begin n_fail++; $display("FAIL wrap_raddr0 got %0d want 15", raddr); end
        rinc = 1'b1;
        step();
        n_checks++; if (rptr !== 5'b00000) begin n_fail++; $display("FAIL wrap_rptr0 got %b want 00000", rptr); end
        n_checks++; if (raddr !== 4'd0) begin n_fail++; $display("FAIL wrap_raddr1 got %0d want 0", raddr); end
        step();
        rinc = 1'b0;
        n_checks++; if (rptr !== 5'b00001) begin n_fail++; $display("FAIL wrap_rptr1 got %b want 00001", rptr); end
        n_checks++; if (raddr !== 4'd1) begin n_fail++; $display("FAIL wrap_raddr2 got %0d want 1", raddr); end
        n_checks++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL wrap_rempty got %b want 1", rempty); end
    endtask

    task automatic test_full_level();
        rrst_n = 1'b0;
        step();
        rrst_n = 1'b1; rq2_wptr = 5'b11000;
        step();
        n_checks++; if (rlevel !== 5'd16) begin n_fail++; $display("FAIL full_rlevel got %0d want 16", rlevel); end
        n_checks++; if (rempty !== 1'b0) begin n_fail++; $display("FAIL full_rempty got %b want 0", rempty); end
        n_checks++; if (raempty !== 1'b0) begin n_fail++; $display("FAIL full_raempty got %b want 0", raempty); end
        aempty_thresh = 5'd16;
        step();
        n_checks++; if (raempty !== 1'b1) begin n_fail++; $display("FAIL full_raempty_t16 got %b want 1", raempty); end
        aempty_thresh = 5'd2;
    endtask

    task automatic test_random();
        int m_rbin, m_wbin, m_level, thresh;
        bit m_empty, m_aempty, m_uf, old_empty, r, c, rst;
        rrst_n = 1'b0; rinc = 1'b0; uf_clr = 1'b0; rq2_wptr = '0;
        step();
        m_rbin = 0; m_wbin = 0; m_level = 0; m_empty = 1; m_aempty = 1; m_uf = 0; thresh = 2;
        for (int i = 0; i < 800; i++) begin
            if (i % 80 == 0) thresh = $urandom_range(0, 17);
            rst = ($urandom_range(0, 59) == 0);
            r   = 1'($urandom_range(0, 1));
            c   = ($urandom_range(0, 7) == 0);
            if (rst) m_wbin = 0;
            else if ($urandom_range(0, 1) == 1 && ((m_wbin - m_rbin) & 31) < 16) m_wbin = (m_wbin + 1) & 31;
            rrst_n = ~rst; rinc = r; uf_clr = c;
            rq2_wptr = gray_of(m_wbin); aempty_thresh = PW'(thresh);
            step();
            if (rst) begin
                m_rbin = 0; m_level = 0; m_empty = 1; m_aempty = 1; m_uf = 0;
            end else begin
                old_empty = m_empty;
                if (r && !m_empty) m_rbin = (m_rbin + 1) & 31;
                m_level  = (m_wbin - m_rbin) & 31;
                m_empty  = (m_level == 0);
                m_aempty = (m_level <= thresh);
                if (r && old_empty) m_uf = 1;
                else if (c) m_uf = 0;
            end
            n_checks++; if (rlevel !== PW'(m_level)) begin n_fail++; $display("FAIL rnd_rlevel[%0d] got %0d want %0d", i, rlevel, m_level); end
            n_checks++; if (rempty !== m_empty) begin n_fail++; $display("FAIL rnd_rempty[%0d] got %b want %b", i, rempty, m_empty); end
            n_checks++; if (raempty !== m_aempty) begin n_fail++; $display("FAIL rnd_raempty[%0d] got %b want %b", i, raempty, m_aempty); end
            n_checks++; if (rptr !== gray_of(m_rbin)) begin n_fail++; $display("FAIL rnd_rptr[%0d] got %b want %b", i, rptr, gray_of(m_rbin)); end
            n_checks++; if (raddr !== AW'(m_rbin)) begin n_fail++; $display("FAIL rnd_raddr[%0d] got %0d want %0d", i, raddr, m_rbin & 15); end
            n_checks++; if (runderflow !== m_uf) begin n_fail++; $display("FAIL rnd_runderflow[%0d] got %b want %b", i, runderflow, m_uf); end
            n_checks++; if (rempty !== (rlevel == 0)) begin n_fail++; $display("FAIL rnd_consistency[%0d] rempty %b rlevel %0d", i, rempty, rlevel); end
        end
        rinc = 1'b0; uf_clr = 1'b0; rrst_n = 1'b1;
    endtask

    initial begin
        rrst_n = 1'b0; rinc = 1'b0; uf_clr = 1'b0; rq2_wptr = '0; aempty_thresh = 5'd2;
        #2;
        test_reset();
        test_fill();
        test_drain();
        test_underflow();
        test_wrap();
        test_full_level();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
